// File: rtl/dac_pkg.sv
// Shared types and constants for the quad SPI DAC output stage:
// FSM states, frame layout and the sample-to-frame packing helper.
package dac_pkg;

  localparam logic [3:0] DAC_CMD_WRITE = 4'b0000;
  localparam int         FRAME_BITS    = 24;
  localparam int         NUM_CH        = 4;
  localparam int         HALF_PERIODS  = 2 * FRAME_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_LDAC,
    ST_DONE
  } dac_state_e;

  // Signed two's-complement sample becomes offset binary by flipping the sign bit.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0]  ch,
                                                        input logic [15:0] sample);
    return {DAC_CMD_WRITE, 2'b00, ch, sample ^ 16'h8000};
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Shifts one 24-bit frame MSB first per start request; sclk idles low and
// mosi changes only on falling edges. frame_done marks the last cs_n-low cycle.
module spi_frame_tx
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  frame_done
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]      H_LAST   = 6'(HALF_PERIODS - 1);

  logic                  active_q, active_d;
  logic [5:0]            h_q, h_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  done_q, done_d;

  always_comb begin
    active_d = active_q;
    h_d      = h_q;
    div_d    = div_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        h_d      = '0;
        div_d    = '0;
        cs_n_d   = 1'b0;
        sclk_d   = 1'b0;
        mosi_d   = frame[FRAME_BITS-1];
        shreg_d  = {frame[FRAME_BITS-2:0], 1'b0};
      end
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        active_d = 1'b0;
        cs_n_d   = 1'b1;
        sclk_d   = 1'b0;
        mosi_d   = 1'b0;
      end else begin
        h_d    = h_q + 6'd1;
        sclk_d = h_d[0];
        // Even half-periods begin with a falling edge: present the next bit.
        if (!h_d[0]) begin
          mosi_d  = shreg_q[FRAME_BITS-1];
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
        end
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    done_d = active_d && (h_d == H_LAST) && (div_d == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      h_q      <= '0;
      div_q    <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      h_q      <= h_d;
      div_q    <= div_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      done_q   <= done_d;
    end
  end

  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;
  assign frame_done = done_q;

endmodule

// File: rtl/dac_quad_spi.sv
// Latches four channel samples on load, sends them as four SPI frames
// separated by gaps, then pulses LDAC so all DAC outputs update together.
module dac_quad_spi
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int LDAC_W  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din1,
  input  logic [15:0] din2,
  input  logic [15:0] din3,
  input  logic [15:0] din4,
  input  logic        load,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        ldac_n,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int               GAP_W     = $clog2(2 * CLK_DIV);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(2 * CLK_DIV - 1);
  localparam int               LDAC_CW   = (LDAC_W > 1) ? $clog2(LDAC_W) : 1;
  localparam logic [LDAC_CW-1:0] LDAC_LAST = LDAC_CW'(LDAC_W - 1);
  localparam logic [1:0]       CH_LAST   = 2'(NUM_CH - 1);

  dac_state_e           state_q;
  logic [1:0]           ch_q;
  logic [15:0]          samples_q [NUM_CH];
  logic [GAP_W-1:0]     gap_cnt_q;
  logic [LDAC_CW-1:0]   ldac_cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 overrun_q;
  logic                 ldac_n_q;

  logic                  accept;
  logic                  tx_start;
  logic [1:0]            tx_ch;
  logic [15:0]           tx_sample;
  logic [FRAME_BITS-1:0] tx_frame;
  logic                  tx_done;

  // Frame 0 is built straight from din so mosi carries bit 23 one cycle after load.
  always_comb begin
    accept    = load && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    tx_start  = 1'b0;
    tx_ch     = ch_q + 2'd1;
    tx_sample = samples_q[tx_ch];
    if (accept) begin
      tx_start  = 1'b1;
      tx_ch     = 2'd0;
      tx_sample = din1;
    end else if ((state_q == ST_GAP) && (gap_cnt_q == '0) && (ch_q != CH_LAST)) begin
      tx_start = 1'b1;
    end
    tx_frame = build_frame(tx_ch, tx_sample);
  end

  spi_frame_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk        (clk),
    .rst_n      (rst),
    .start      (tx_start),
    .frame      (tx_frame),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .frame_done (tx_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) samples_q[i] <= '0;
      gap_cnt_q  <= '0;
      ldac_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      ldac_n_q   <= 1'b1;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= load && busy_q;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (load) begin
            samples_q[0] <= din1;
            samples_q[1] <= din2;
            samples_q[2] <= din3;
            samples_q[3] <= din4;
            ch_q         <= '0;
            busy_q       <= 1'b1;
            state_q      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tx_done) begin
            gap_cnt_q <= GAP_LAST;
            state_q   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            if (ch_q == CH_LAST) begin
              ldac_n_q   <= 1'b0;
              ldac_cnt_q <= LDAC_LAST;
              state_q    <= ST_LDAC;
            end else begin
              ch_q    <= ch_q + 2'd1;
              state_q <= ST_SHIFT;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        ST_LDAC: begin
          if (ldac_cnt_q == '0) begin
            ldac_n_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            ldac_cnt_q <= ldac_cnt_q - LDAC_CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ldac_n  = ldac_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
